// File: rtl/exc_ctrl_pkg.sv
// Shared encodings for the exception controller, PC-source mux and main control.
package exc_ctrl_pkg;

    typedef logic [2:0] state_t;
    typedef logic [2:0] pc_src_t;
    typedef logic [1:0] cause_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_LOAD    = 3'd3;
    localparam logic [2:0] ST_RETURN  = 3'd4;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [1:0] CAUSE_OVF    = 2'b10;
    localparam logic [1:0] CAUSE_DIV0   = 2'b11;

    localparam logic [2:0] PCSRC_JUMP    = 3'b000;
    localparam logic [2:0] PCSRC_RESULT  = 3'b001;
    localparam logic [2:0] PCSRC_ALUOUT  = 3'b010;
    localparam logic [2:0] PCSRC_MEMDATA = 3'b011;
    localparam logic [2:0] PCSRC_EPC     = 3'b100;

    // Fixed priority: bad opcode over overflow over divide-by-zero.
    function automatic cause_t exc_cause(input logic bad_opcode, input logic ovf,
                                         input logic div_zero);
        if (bad_opcode)    return CAUSE_OPCODE;
        else if (ovf)      return CAUSE_OVF;
        else if (div_zero) return CAUSE_DIV0;
        else               return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/exc_ctrl.sv
// Exception controller: saves EPC/cause, fetches the handler vector from memory,
// redirects the PC to the handler, and services return-from-exception.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255,
    parameter int          MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bad_opcode,
    input  logic        ovf,
    input  logic        div_zero,
    input  logic        eret,
    input  logic [31:0] pc_cur,
    input  logic [31:0] mem_data,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic [31:0] epc,
    output logic [31:0] exc_target,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic        exc_busy,
    output logic [1:0]  cause
);

    localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  wait_cnt;
    logic        exc_req;
    logic        wait_done;
    logic [31:0] vec_addr;
    logic        unused_mem_hi;

    assign exc_req       = bad_opcode | ovf | div_zero;
    assign wait_done     = (state == ST_WAIT) && (wait_cnt == CNT_LAST);
    assign unused_mem_hi = ^mem_data[31:8];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (exc_req)   state_nxt = ST_CAPTURE;
                else if (eret) state_nxt = ST_RETURN;
            end
            ST_CAPTURE: state_nxt = ST_WAIT;
            ST_WAIT:    if (wait_done) state_nxt = ST_LOAD;
            ST_LOAD:    state_nxt = ST_IDLE;
            ST_RETURN:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= 2'd0;
            epc        <= 32'd0;
            exc_target <= 32'd0;
            cause      <= CAUSE_NONE;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && exc_req) begin
                epc   <= pc_cur - 32'd4;
                cause <= exc_cause(bad_opcode, ovf, div_zero);
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_done ? 2'd0 : wait_cnt + 2'd1;
            end
            // Memory data is valid in the last WAIT cycle; capture it for LOAD.
            if (wait_done) begin
                exc_target <= {24'd0, mem_data[7:0]};
            end
        end
    end

    always_comb begin
        case (cause)
            CAUSE_OPCODE: vec_addr = VEC_OPCODE;
            CAUSE_OVF:    vec_addr = VEC_OVF;
            CAUSE_DIV0:   vec_addr = VEC_DIV0;
            default:      vec_addr = 32'd0;
        endcase
    end

    // Strobes are gated by reset_n so an abort never emits a write in the reset cycle.
    always_comb begin
        mem_addr  = 32'd0;
        mem_read  = 1'b0;
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b0;
        case (state)
            ST_CAPTURE: begin
                mem_addr = vec_addr;
                mem_read = reset_n;
            end
            ST_WAIT: mem_addr = vec_addr;
            ST_LOAD: begin
                pc_source = PCSRC_MEMDATA;
                pc_write  = reset_n;
            end
            ST_RETURN: begin
                pc_source = PCSRC_EPC;
                pc_write  = reset_n;
            end
            default: ;
        endcase
    end

    assign exc_busy = (state != ST_IDLE);

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter VEC_OPCODE, default 32'd253, meaning memory byte address holding the invalid-opcode handler address.
REQ-002 SHALL have parameter VEC_OVF, default 32'd254, meaning memory byte address holding the overflow handler address.
REQ-003 SHALL have parameter VEC_DIV0, default 32'd255, meaning memory byte address holding the divide-by-zero handler address.
REQ-004 SHALL have parameter MEM_LAT, default 1, range 1..3, meaning cycles from mem_read assertion to valid mem_data.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk input 1 (single clock, rising edge); reset_n input 1 (synchronous, active-low).
REQ-006 SHALL have the following exception request inputs, each 1 bit and sampled only in IDLE: bad_opcode (decoder found an undefined opcode/funct); ovf (ALU signed overflow); div_zero (divider saw a zero divisor).
REQ-007 SHALL have the following data inputs: eret (input, 1, return-from-exception request); pc_cur (input, 32, current PC, already incremented by 4); mem_data (input, 32, memory read data).
REQ-008 SHALL have the following memory-side outputs: mem_addr (output, 32, vector address to memory); mem_read (output, 1, memory read strobe).
REQ-009 SHALL have the following PC-path outputs: epc (output, 32, saved return address, feeds EPCReg of PC-source mux); exc_target (output, 32, zero-extended handler address, feeds memData of PC-source mux); pc_source (output, 3, PC-source mux select); pc_write (output, 1, PC register write enable).
REQ-010 SHALL have the following status outputs: exc_busy (output, 1, stalls main control while high); cause (output, 2, 00 none, 01 opcode, 10 ovf, 11 div0).

Function
REQ-011 SHALL implement FSM states IDLE, CAPTURE, WAIT, LOAD, RETURN.
REQ-012 In IDLE, any of bad_opcode/ovf/div_zero high SHALL move to CAPTURE next cycle; otherwise, eret high SHALL move to RETURN.
REQ-013 Simultaneous requests SHALL resolve with priority bad_opcode > ovf > div_zero, and any exception SHALL have priority over eret.
REQ-014 On the IDLE->CAPTURE edge, the FSM SHALL register epc <= pc_cur - 4 (mod 2^32) and cause per the winning request.
REQ-015 In CAPTURE, the FSM SHALL drive mem_addr to the vector for the registered cause and mem_read=1 for exactly one cycle, then go to WAIT.
REQ-016 WAIT SHALL last MEM_LAT cycles, counted by an internal counter; mem_addr SHALL be held at the vector address throughout.
REQ-017 In LOAD, the FSM SHALL drive exc_target = {24'b0, mem_data[7:0]}, pc_source=3'b011, pc_write=1 for exactly one cycle, then return to IDLE.
REQ-018 In RETURN, the FSM SHALL drive pc_source=3'b100, pc_write=1 for exactly one cycle, then return to IDLE; epc SHALL be unchanged.
REQ-019 Exception latency SHALL be fixed: request edge to pc_write pulse = 2 + MEM_LAT cycles.
REQ-020 exc_busy SHALL be high in every state except IDLE, and requests arriving while exc_busy is high SHALL be ignored, not queued.
REQ-021 In IDLE, pc_write=0, mem_read=0, pc_source=3'b000, and mem_addr=0.
REQ-022 exc_target SHALL be registered, holding the last loaded value until the next LOAD.
REQ-023 pc_cur < 4 SHALL wrap, e.g. pc_cur=0 gives epc=32'hFFFF_FFFC.

Reset
REQ-024 reset_n=0 at a clock edge SHALL force IDLE, with epc=0, exc_target=0, cause=00, WAIT counter=0, and all strobes 0.
REQ-025 Reset asserted mid-sequence (any state) SHALL abort with no pc_write pulse on that or the following cycle.

Structure
REQ-026 The state encoding, cause codes, and pc_source select codes (000 jump, 001 result, 010 aluOut, 011 memData, 100 EPC) SHALL live in a shared package also used by the PC-source mux and main control.
REQ-027 The block SHALL be a single module with no sub-module; the FSM, counter, and epc/exc_target registers SHALL be inline.

Verification
REQ-028 Scenario: ovf=1 for 1 cycle, pc_cur=32'h0000_0040, MEM_LAT=1, mem byte 254=8'h80 -> epc=32'h3C, cause=10, mem_addr=254, pc_write with pc_source=011 and exc_target=32'h80 on cycle 3.
REQ-029 Scenario: bad_opcode=ovf=div_zero=1 together -> cause=01, mem_addr=253.
REQ-030 Scenario: eret=1 in IDLE with epc=32'h3C -> one-cycle pc_write, pc_source=100, exc_busy high 1 cycle.
REQ-031 Scenario: div_zero during WAIT -> ignored, single pc_write, cause stays at first value.
REQ-032 Scenario: reset_n=0 during WAIT -> next cycle IDLE, epc=0, no pc_write.
REQ-033 Scenario: pc_cur=0 with div_zero, MEM_LAT=3 -> epc=32'hFFFF_FFFC, pc_write exactly 5 cycles after request.
